// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default build uses a registered read.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AE_THRESH = 1,
    parameter int AF_THRESH = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          data_in_i,
    input  logic                       clr_err_i,
    output logic [DATA_W-1:0]          data_out_o,
    output logic                       empty_o,
    output logic                       almost_empty_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic empty_w, full_w;
    logic push_ok, pop_ok;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_FULL);

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign pop_ok  = pop_i & ~empty_w;
    assign push_ok = push_i & (~full_w | pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err_i;
        underflow_d = underflow_q & ~clr_err_i;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh error outranks clr_err in the same cycle.
        if (push_i & ~push_ok) begin
            overflow_d = 1'b1;
        end
        if (pop_i & ~pop_ok) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem[wr_ptr_q] <= data_in_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    always_comb begin
        data_out_o = '0;
        if (!empty_w) begin
            data_out_o = mem[rd_ptr_q];
        end
    end
`else
    logic [DATA_W-1:0] data_out_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_out_q <= '0;
        end else if (pop_ok) begin
            data_out_q <= mem[rd_ptr_q];
        end
    end

    assign data_out_o = data_out_q;
`endif

    assign empty_o        = empty_w;
    assign full_o         = full_w;
    assign almost_empty_o = (count_q <= CNT_AE);
    assign almost_full_o  = (count_q >= CNT_AF);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule
